// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result select, destination
// select, load size and FSM state encodings.
package wb_pkg;

   // Result select (in_wb_sel)
   localparam logic [1:0] WB_MEM = 2'd0;
   localparam logic [1:0] WB_ALU = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   // Destination select (in_dst_sel); DST_NONE means no register write
   localparam logic [1:0] DST_RT   = 2'd0;
   localparam logic [1:0] DST_RD   = 2'd1;
   localparam logic [1:0] DST_LINK = 2'd2;
   localparam logic [1:0] DST_NONE = 2'd3;

   // Load size (in_ld_size); the spare code behaves as a word load
   localparam logic [1:0] LD_BYTE     = 2'd0;
   localparam logic [1:0] LD_HALF     = 2'd1;
   localparam logic [1:0] LD_WORD     = 2'd2;
   localparam logic [1:0] LD_WORD_ALT = 2'd3;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_MEM = 2'd1;
   localparam logic [1:0] ST_WRITE    = 2'd2;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      WAIT_MEM = ST_WAIT_MEM,
      WRITE    = ST_WRITE
   } state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/half/word from a
// 32-bit memory word, sign- or zero-extends it and flags misalignment.
// Ports:
//   word      in  32      raw load data
//   size      in  2       load size (byte/half/word)
//   is_signed in  1       sign-extend when set
//   off       in  2       byte offset within the word
//   data      out DATA_W  aligned, extended result
//   misalign  out 1       access not naturally aligned
module load_align
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [31:0]       word,
   input  logic [1:0]        size,
   input  logic              is_signed,
   input  logic [1:0]        off,
   output logic [DATA_W-1:0] data,
   output logic              misalign
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      data     = '0;
      misalign = 1'b0;
      byte_v   = word[{off, 3'b000} +: 8];
      half_v   = word[{off[1], 4'b0000} +: 16];
      case (size)
         LD_BYTE: begin
            data = is_signed ? DATA_W'($signed(byte_v)) : DATA_W'(byte_v);
         end
         LD_HALF: begin
            data     = is_signed ? DATA_W'($signed(half_v)) : DATA_W'(half_v);
            misalign = off[0];
         end
         LD_WORD, LD_WORD_ALT: begin
            data     = is_signed ? DATA_W'($signed(word)) : DATA_W'(word);
            misalign = (off != 2'd0);
         end
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one instruction result per handshake, waits for
// load data when needed, and issues a single register-file write.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   in_alu_res, in_pc4, in_imm  candidate results
//   in_rt, in_rd, in_dst_sel    destination selection
//   in_wb_sel, in_reg_write     result select, write enable
//   in_ld_size, in_ld_signed, in_byte_off  load shaping
//   mem_rdata, mem_rvalid       load data return
//   rf_we, rf_waddr, rf_wdata   register-file write port (registered)
//   misalign_err                misaligned-load pulse (registered)
module wb_stage
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_pc4,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [REG_AW-1:0] in_rt,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [1:0]        in_dst_sel,
   input  logic [1:0]        in_wb_sel,
   input  logic              in_reg_write,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_signed,
   input  logic [1:0]        in_byte_off,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              misalign_err
);

   state_t state;

   logic [DATA_W-1:0] r_alu_res, r_pc4, r_imm;
   logic [REG_AW-1:0] r_rt, r_rd;
   logic [1:0]        r_dst_sel, r_wb_sel, r_ld_size, r_byte_off;
   logic              r_reg_write, r_ld_signed;

   // Field view feeding the write computation: live inputs when a transfer
   // can happen, captured fields while waiting for load data.
   logic              use_in;
   logic [DATA_W-1:0] s_alu_res, s_pc4, s_imm;
   logic [REG_AW-1:0] s_rt, s_rd;
   logic [1:0]        s_dst_sel, s_wb_sel, s_ld_size, s_byte_off;
   logic              s_reg_write, s_ld_signed;

   logic [DATA_W-1:0] ld_data;
   logic              ld_misalign;
   logic              xfer;
   logic              nxt_we, nxt_mis;
   logic [REG_AW-1:0] nxt_waddr;
   logic [DATA_W-1:0] nxt_wdata;

   assign in_ready = !rst && (state != WAIT_MEM);
   assign xfer     = in_valid && in_ready;
   assign use_in   = (state != WAIT_MEM);

   assign s_alu_res   = use_in ? in_alu_res   : r_alu_res;
   assign s_pc4       = use_in ? in_pc4       : r_pc4;
   assign s_imm       = use_in ? in_imm       : r_imm;
   assign s_rt        = use_in ? in_rt        : r_rt;
   assign s_rd        = use_in ? in_rd        : r_rd;
   assign s_dst_sel   = use_in ? in_dst_sel   : r_dst_sel;
   assign s_wb_sel    = use_in ? in_wb_sel    : r_wb_sel;
   assign s_ld_size   = use_in ? in_ld_size   : r_ld_size;
   assign s_byte_off  = use_in ? in_byte_off  : r_byte_off;
   assign s_reg_write = use_in ? in_reg_write : r_reg_write;
   assign s_ld_signed = use_in ? in_ld_signed : r_ld_signed;

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .word      (mem_rdata[31:0]),
      .size      (s_ld_size),
      .is_signed (s_ld_signed),
      .off       (s_byte_off),
      .data      (ld_data),
      .misalign  (ld_misalign)
   );

   // Write-port values to be loaded on entry to WRITE
   always_comb begin
      nxt_waddr = '0;
      nxt_wdata = '0;
      nxt_mis   = 1'b0;
      nxt_we    = 1'b0;
      case (s_dst_sel)
         DST_RT:   nxt_waddr = s_rt;
         DST_RD:   nxt_waddr = s_rd;
         DST_LINK: nxt_waddr = REG_AW'(LINK_REG);
         DST_NONE: nxt_waddr = '0;
      endcase
      case (s_wb_sel)
         WB_MEM: nxt_wdata = ld_data;
         WB_ALU: nxt_wdata = s_alu_res;
         WB_PC4: nxt_wdata = s_pc4;
         WB_IMM: nxt_wdata = s_imm;
      endcase
      nxt_mis = (s_wb_sel == WB_MEM) && ld_misalign;
      nxt_we  = s_reg_write && (s_dst_sel != DST_NONE) &&
                (nxt_waddr != '0) && !nxt_mis;
   end

   // FSM, field capture and registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         misalign_err <= 1'b0;
         r_alu_res    <= '0;
         r_pc4        <= '0;
         r_imm        <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_dst_sel    <= '0;
         r_wb_sel     <= '0;
         r_ld_size    <= '0;
         r_byte_off   <= '0;
         r_reg_write  <= 1'b0;
         r_ld_signed  <= 1'b0;
      end else begin
         rf_we        <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE, WRITE: begin
               if (xfer) begin
                  r_alu_res   <= in_alu_res;
                  r_pc4       <= in_pc4;
                  r_imm       <= in_imm;
                  r_rt        <= in_rt;
                  r_rd        <= in_rd;
                  r_dst_sel   <= in_dst_sel;
                  r_wb_sel    <= in_wb_sel;
                  r_ld_size   <= in_ld_size;
                  r_byte_off  <= in_byte_off;
                  r_reg_write <= in_reg_write;
                  r_ld_signed <= in_ld_signed;
                  if (in_wb_sel == WB_MEM) begin
                     state <= WAIT_MEM;
                  end else begin
                     state        <= WRITE;
                     rf_we        <= nxt_we;
                     rf_waddr     <= nxt_waddr;
                     rf_wdata     <= nxt_wdata;
                     misalign_err <= nxt_mis;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_MEM: begin
               if (mem_rvalid) begin
                  state        <= WRITE;
                  rf_we        <= nxt_we;
                  rf_waddr     <= nxt_waddr;
                  rf_wdata     <= nxt_wdata;
                  misalign_err <= nxt_mis;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-file data width (multiple of 16, at least 32).
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter LINK_REG, default 31, destination index used for link writes.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid in 1 and in_ready out 1: upstream handshake; a transfer occurs when both are high.
REQ-007 SHALL have ports in_alu_res, in_pc4, in_imm  in  DATA_W each: ALU result, PC+4 and upper immediate.
REQ-008 SHALL have ports in_rt, in_rd  in  REG_AW each: candidate destination indices.
REQ-009 SHALL have port in_dst_sel  in  2  destination select: 0=rt, 1=rd, 2=LINK_REG, 3=reserved, treated as no write.
REQ-010 SHALL have port in_wb_sel  in  2  result select: 0=memory, 1=ALU, 2=pc4, 3=imm.
REQ-011 SHALL have ports in_reg_write in 1, in_ld_size in 2 (0=byte, 1=half, 2=word), in_ld_signed in 1 and in_byte_off in 2.
REQ-012 SHALL have ports mem_rdata  in  DATA_W  and mem_rvalid  in  1: load data return, valid for one cycle.
REQ-013 SHALL have ports rf_we out 1, rf_waddr out REG_AW and rf_wdata out DATA_W: register-file write port.
REQ-014 SHALL have port misalign_err  out  1  one-cycle pulse for a misaligned load.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT_MEM and WRITE.
REQ-016 SHALL drive in_ready=1 in IDLE and WRITE, and in_ready=0 in WAIT_MEM.
REQ-017 SHALL register all in_* fields on a transfer.
REQ-018 SHALL go to WAIT_MEM on a transfer with in_wb_sel=0, and to WRITE on any other transfer.
REQ-019 SHALL leave WAIT_MEM for WRITE on the first cycle with mem_rvalid=1, capturing mem_rdata, with no timeout.
REQ-020 SHALL go from WRITE to IDLE when there is no transfer; a transfer in WRITE SHALL follow REQ-018, giving back-to-back writes.
REQ-021 SHALL ignore mem_rvalid in IDLE and WRITE.
REQ-022 SHALL assert rf_we for exactly one cycle, in WRITE only, when reg_write=1, dst_sel!=3, destination!=0 and no misalign.
REQ-023 SHALL give latency: non-load writes one cycle after transfer; loads one cycle after mem_rvalid.
REQ-024 SHALL, for byte loads, select the byte mem_rdata[8*off+7:8*off] and then sign- or zero-extend it to DATA_W per ld_signed.
REQ-025 SHALL, for half loads, select half off[1] and then extend; off[0]=1 is misaligned.
REQ-026 SHALL, for word loads, pass the low 32 bits and extend to DATA_W; off!=0 is misaligned.
REQ-027 SHALL, on a misaligned load, pulse misalign_err in WRITE with rf_we=0.
REQ-028 SHALL treat in_ld_size=3 as a word load.
REQ-029 SHALL hold rf_waddr and rf_wdata stable from the registered fields throughout WRITE.

Reset
REQ-030 SHALL, on rst=1, force the FSM to IDLE and set rf_we=0, rf_waddr=0, rf_wdata=0 and misalign_err=0 on that clock edge.
REQ-031 SHALL, on rst during WAIT_MEM or WRITE, drop the pending transaction with no write, and ignore any later mem_rvalid for it.
REQ-032 SHALL drive in_ready=0 while rst=1.

Structure
REQ-033 SHALL place the wb_sel, dst_sel, ld_size encodings and state encodings as localparams in shared package wb_pkg.
REQ-034 SHALL implement load byte/half select plus extension in combinational sub-module load_align.

Verification
REQ-035 SHALL cover: ALU write, wb_sel=1, rd=8, alu=0x12345678 -> next cycle rf_we=1, waddr=8, wdata=0x12345678.
REQ-036 SHALL cover: signed byte load, off=3, mem_rdata=0x80FF0000 arriving 3 cycles late -> in_ready=0 for 3 cycles; then wdata=0xFFFFFF80.
REQ-037 SHALL cover: unsigned half load, off=2, mem_rdata=0xBEEF1234 -> wdata=0x0000BEEF; half load with off=1 -> misalign_err=1, rf_we=0.
REQ-038 SHALL cover: link write, dst_sel=2, pc4=0x00400010 -> waddr=31, wdata=0x00400010; a destination of 0 with reg_write=1 -> rf_we stays 0.
REQ-039 SHALL cover: back-to-back ALU transfers on consecutive cycles -> rf_we high on two consecutive cycles with the correct data.
REQ-040 SHALL cover: rst asserted in WAIT_MEM, then mem_rvalid=1 -> no rf_we, state IDLE, in_ready=1 after rst falls.
